// File: rtl/quarter_period_estimator.sv
// Measures sig_in period in sclock cycles and emits period/4 (saturated to 255); QPE_AVG_EN averages 4 periods.
// Result registers 1 cycle after the qualifying edge; a full unread register drops new results and flags overrun.
module quarter_period_estimator #(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_PERIOD     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       sclock,
    input  logic       rst_n,
    input  logic       rt,
    input  logic       sig_in,
    output logic [7:0] count_quater_period,
    output logic       valid,
    input  logic       ready,
    output logic       sat,
    output logic       overrun,
    output logic       timeout
);
    localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);
    localparam logic [31:0] TO_P  = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sig_prev_q, sig_prev_d;
    logic                   edge_q, edge_d;
    state_t                 state_q, state_d;
    logic [31:0]            period_cnt_q, period_cnt_d;
    logic [7:0]             result_q, result_d;
    logic                   valid_q, valid_d;
    logic                   sat_q, sat_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;

    logic                   accept;
    logic                   res_vld;
    logic [29:0]            quarter;

`ifdef QPE_AVG_EN
    logic [33:0]            acc_q, acc_d, acc_sum;
    logic [1:0]             nacc_q, nacc_d;
    logic                   glitch;
`endif

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], sig_in};
        sig_prev_d   = sync_q[SYNC_STAGES-1];
        edge_d       = sync_q[SYNC_STAGES-1] & ~sig_prev_q;

        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        result_d     = result_q;
        valid_d      = valid_q & ~ready;
        sat_d        = sat_q;
        overrun_d    = overrun_q & ~(valid_q & ready);
        timeout_d    = 1'b0;
        accept       = 1'b0;

        // Glitch edges fall through to the plain increment branch.
        case (state_q)
            IDLE: begin
                period_cnt_d = '0;
                if (rt) state_d = ARM;
            end
            ARM: begin
                period_cnt_d = '0;
                if (edge_q) begin
                    state_d      = MEASURE;
                    period_cnt_d = 32'd1;
                end
            end
            MEASURE: begin
                if (edge_q && period_cnt_q >= MIN_P) begin
                    accept       = 1'b1;
                    period_cnt_d = 32'd1;
                end else if (period_cnt_q == TO_P) begin
                    timeout_d    = 1'b1;
                    period_cnt_d = '0;
                    state_d      = ARM;
                end else begin
                    period_cnt_d = period_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef QPE_AVG_EN
        glitch  = (state_q == MEASURE) && edge_q && (period_cnt_q < MIN_P);
        acc_sum = acc_q + 34'(period_cnt_q);
        acc_d   = acc_q;
        nacc_d  = nacc_q;
        res_vld = 1'b0;
        quarter = acc_sum[33:4];
        if (accept) begin
            if (nacc_q == 2'd3) begin
                res_vld = 1'b1;
                acc_d   = '0;
                nacc_d  = '0;
            end else begin
                acc_d   = acc_sum;
                nacc_d  = nacc_q + 2'd1;
            end
        end
        if (glitch || timeout_d || state_q != MEASURE) begin
            acc_d  = '0;
            nacc_d = '0;
        end
`else
        res_vld = accept;
        quarter = period_cnt_q[31:2];
`endif

        if (res_vld) begin
            if (!valid_q || ready) begin
                valid_d  = 1'b1;
                sat_d    = |quarter[29:8];
                result_d = (|quarter[29:8]) ? 8'hFF : quarter[7:0];
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Dropping rt abandons any measurement and returns outputs to idle values.
        if (!rt) begin
            state_d      = IDLE;
            period_cnt_d = '0;
            result_d     = '0;
            valid_d      = 1'b0;
            sat_d        = 1'b0;
            overrun_d    = 1'b0;
            timeout_d    = 1'b0;
`ifdef QPE_AVG_EN
            acc_d        = '0;
            nacc_d       = '0;
`endif
        end
    end

    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            sig_prev_q   <= 1'b0;
            edge_q       <= 1'b0;
            state_q      <= IDLE;
            period_cnt_q <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
            sat_q        <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef QPE_AVG_EN
            acc_q        <= '0;
            nacc_q       <= '0;
`endif
        end else begin
            sync_q       <= sync_d;
            sig_prev_q   <= sig_prev_d;
            edge_q       <= edge_d;
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            sat_q        <= sat_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
`ifdef QPE_AVG_EN
            acc_q        <= acc_d;
            nacc_q       <= nacc_d;
`endif
        end
    end

    assign count_quater_period = result_q;
    assign valid               = valid_q;
    assign sat                 = sat_q;
    assign overrun             = overrun_q;
    assign timeout             = timeout_q;

endmodule

// File: doc/quarter_period_estimator.md
# quarter_period_estimator

Measures the period of an external periodic signal in `sclock` cycles and derives the quarter-period count that the quarter-period delay trigger consumes on its 8-bit `count_quater_period` input. It sits on the measurement input path ahead of the trigger generator. Results go to the trigger generator and the C server through a valid/ready register, so the delay tracks the real signal instead of a hand-entered value.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `sig_in` (≥2).
- `MIN_PERIOD`, 8: detected edges closer than this many cycles are glitches and are ignored.
- `TIMEOUT_CYCLES`, 1000000: cycles without an accepted edge before a timeout is declared (< 2^32).

Ports:
- `sclock`  in  1  sole clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rt`  in  1  run enable; 0 holds the block idle.
- `sig_in`  in  1  asynchronous measured signal.
- `count_quater_period`  out  8  quarter-period result; holds when not valid.
- `valid`  out  1  result available.
- `ready`  in  1  consumer accepts; transfer when `valid && ready`.
- `sat`  out  1  result saturated at 255; qualified by `valid`.
- `overrun`  out  1  sticky: a result was dropped because the register was full. Cleared on transfer or when `rt`=0.
- `timeout`  out  1  one-cycle pulse on timeout.

## Operation
- `sig_in` passes through `SYNC_STAGES` flops, then a rising-edge detector producing `edge`.
- 32-bit `period_cnt` increments every cycle in MEASURE.
- The FSM has three states:
  - IDLE: entered when `rt`=0. Counter is 0, `valid`=0, `overrun`=0. Goes to ARM when `rt`=1.
  - ARM: counter held at 0. The first `edge` moves to MEASURE with counter = 1.
  - MEASURE: on `edge` with P = `period_cnt` ≥ `MIN_PERIOD`:
    - compute Q = P >> 2 (truncating);
    - if Q > 255, the result is 255 with `sat`=1; otherwise Q with `sat`=0;
    - counter restarts at 1.
  - MEASURE, glitch: `edge` with P < `MIN_PERIOD` is ignored and the counter keeps running.
  - MEASURE, timeout: `period_cnt` == `TIMEOUT_CYCLES` pulses `timeout`, clears the counter and returns to ARM.
- Result load:
  - The result loads if `valid`=0, or if `valid && ready` in the same cycle.
  - Otherwise the result is dropped, `overrun` is set, and the held value is unchanged.
- `rt` falling in any state goes to IDLE on the next edge. An in-flight measurement is discarded.

## Timing
- Reset values: `count_quater_period`=0, `valid`=0, `sat`=0, `overrun`=0, `timeout`=0. FSM is in IDLE with the counter at 0.
- Latency from a `sig_in` rising transition to `edge` is `SYNC_STAGES`+1 cycles.
- `valid` and the new result appear the cycle after the qualifying `edge`.
- `valid` falls the cycle after a transfer unless a new result loads in that same cycle. In that case `valid` stays 1 with new data.
- An `edge` that coincides with the timeout cycle is treated as the edge; no timeout occurs.
- Measured P equals the true period in `sclock` cycles, ±1 from synchronizer phase.
- Asserting `rst_n` mid-measurement forces all reset values immediately, with no output glitch pulse on release.

## Configuration
- `QPE_AVG_EN` defined:
  - The block accumulates 4 consecutive accepted periods in a 34-bit sum.
  - Result = sum >> 4, saturated to 255 as above.
  - One result is produced per 4 periods.
  - Timeout, glitch, `rt` and reset all clear the accumulator and the period count.
- `QPE_AVG_EN` undefined: one result per accepted period, with no accumulator logic.

## Test plan
- Basic measurement: `rt`=1, `ready`=1, `sig_in` square wave with period 400 cycles. Required: first `valid` one cycle after the second detected edge, `count_quater_period`=100 (±1 LSB from phase), `sat`=0, repeating every 400 cycles.
- Saturation: period 2000. Required: `count_quater_period`=255, `sat`=1.
- Backpressure: period 400, `ready`=0 across 3 edges. Required: first value held, `valid`=1, `overrun`=1. Raising `ready` for one cycle transfers the value and clears `overrun`.
- Glitch and timeout:
  - A 3-cycle-spaced spurious edge inside a 400-cycle period is ignored; the next result is still 100.
  - Stopping `sig_in`: `timeout` pulses once `TIMEOUT_CYCLES` after the last edge, and the FSM returns to ARM.
- Reset and `rt` mid-operation: drop `rst_n`, or `rt`, halfway through a period with `valid`=1. Required: all outputs return to reset values, and the next result needs two fresh edges.
- With `QPE_AVG_EN`, periods 400, 404, 396, 400. Required: a single result, (1600 >> 4) = 100, after the fourth period.
